// File: rtl/odd_even_merge.sv
// Pairs alternating odd/even nibbles from the shunt stage into bytes {even,odd},
// checks them against the 9..1,F frame sequence and queues bytes in a FWFT FIFO.
module odd_even_merge #(
    parameter int DEPTH  = 4,
    parameter int FCNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              dclk_i,
    input  logic [3:0]        odd_i,
    input  logic [3:0]        even_i,
    output logic [7:0]        out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic              seq_err_o,
    output logic              overflow_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EVEN = 2'd1,
        WAIT_ODD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        lo_q, lo_d;
    logic [3:0]        exp_q, exp_d;
    logic              seq_err_q, seq_err_d;
    logic              overflow_q, overflow_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [7:0]        mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;

    logic              nib_accept;
    logic [3:0]        nib;
    logic              pair_done;
    logic [7:0]        pair_byte;
    logic              full;
    logic              pop;
    logic              push_ok;

    // Values outside 9..1,F can never match, so they restart the frame at 9.
    function automatic logic [3:0] seq_succ(input logic [3:0] v);
        logic [3:0] s;
        if (v == 4'hF)
            s = 4'h9;
        else if (v == 4'h1)
            s = 4'hF;
        else if (v >= 4'h2 && v <= 4'h9)
            s = v - 4'h1;
        else
            s = 4'h9;
        return s;
    endfunction

    assign full        = (count_q == (AW+1)'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign pop         = out_valid_o && out_ready_i;
    assign push_ok     = pair_done && (!full || pop);
    assign frame_cnt_o = frame_cnt_q;
    assign seq_err_o   = seq_err_q;
    assign overflow_o  = overflow_q;

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        exp_d       = exp_q;
        seq_err_d   = seq_err_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        nib_accept  = 1'b0;
        nib         = 4'h0;
        pair_done   = 1'b0;
        pair_byte   = 8'h00;

        // Only the bus selected by dclk is ever read; the other one is floating.
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!dclk_i) begin
                        lo_d       = odd_i;
                        nib        = odd_i;
                        nib_accept = 1'b1;
                        state_d    = WAIT_EVEN;
                    end
                end
                WAIT_EVEN: begin
                    if (dclk_i) begin
                        nib        = even_i;
                        nib_accept = 1'b1;
                        pair_done  = 1'b1;
                        pair_byte  = {even_i, lo_q};
                        state_d    = WAIT_ODD;
                    end else begin
                        seq_err_d  = 1'b1;
                        lo_d       = odd_i;
                        nib        = odd_i;
                        nib_accept = 1'b1;
                    end
                end
                WAIT_ODD: begin
                    if (!dclk_i) begin
                        lo_d       = odd_i;
                        nib        = odd_i;
                        nib_accept = 1'b1;
                        state_d    = WAIT_EVEN;
                    end else begin
                        seq_err_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (nib_accept) begin
            if (nib != exp_q)
                seq_err_d = 1'b1;
            exp_d = seq_succ(nib);
        end

        if (pair_done) begin
            if (pair_byte[7:4] == 4'hF)
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            if (full && !pop)
                overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lo_q        <= 4'h0;
            exp_q       <= 4'h9;
            seq_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            exp_q       <= exp_d;
            seq_err_q   <= seq_err_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= pair_byte;
    end

endmodule

// File: tb/tb_odd_even_merge.sv
// Randomised and directed bench for odd_even_merge with a queue-based scoreboard
// fed by a frame-level reference model.
module tb_odd_even_merge;

    localparam int DEPTH  = 4;
    localparam int FCNT_W = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              en_i;
    logic              dclk_i;
    logic [3:0]        odd_i;
    logic [3:0]        even_i;
    logic [7:0]        out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [FCNT_W-1:0] frame_cnt_o;
    logic              seq_err_o;
    logic              overflow_o;

    int errors = 0;
    int checks = 0;

    logic [3:0]        seqTab [10] = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'hF};

    bit                mStarted;
    bit                mHaveLo;
    logic [3:0]        mLo;
    int                mIdx;
    bit                mErr;
    bit                mOvf;
    logic [FCNT_W-1:0] mFrames;
    logic [7:0]        expQ [$];

    int                upPos;
    bit                upPhase;

    odd_even_merge #(.DEPTH(DEPTH), .FCNT_W(FCNT_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .dclk_i      (dclk_i),
        .odd_i       (odd_i),
        .even_i      (even_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .frame_cnt_o (frame_cnt_o),
        .seq_err_o   (seq_err_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mStarted = 1'b0;
        mHaveLo  = 1'b0;
        mLo      = 4'h0;
        mIdx     = 0;
        mErr     = 1'b0;
        mOvf     = 1'b0;
        mFrames  = '0;
        expQ.delete();
    endtask

    // A wrong nibble restarts the expected sequence just after wherever that value sits in the frame.
    task automatic checkNib(input logic [3:0] v);
        if (v == seqTab[mIdx]) begin
            mIdx = (mIdx + 1) % 10;
        end else begin
            mErr = 1'b1;
            mIdx = 0;
            for (int k = 0; k < 10; k++)
                if (seqTab[k] == v)
                    mIdx = (k + 1) % 10;
        end
    endtask

    task automatic modelStep();
        logic [7:0] b;
        if (!en_i) begin
            mStarted = 1'b0;
            mHaveLo  = 1'b0;
        end else if (!dclk_i) begin
            if (mHaveLo)
                mErr = 1'b1;
            checkNib(odd_i);
            mLo      = odd_i;
            mHaveLo  = 1'b1;
            mStarted = 1'b1;
        end else if (mHaveLo) begin
            checkNib(even_i);
            b       = {even_i, mLo};
            mHaveLo = 1'b0;
            if (even_i == 4'hF)
                mFrames = mFrames + 1'b1;
            if (expQ.size() < DEPTH)
                expQ.push_back(b);
            else
                mOvf = 1'b1;
        end else if (mStarted) begin
            mErr = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        if (rst_ni)
            modelStep();
    end

    // Monitor: handshakes seen here complete at the following rising edge.
    initial forever begin
        @(negedge clk_i);
        if (rst_ni) begin
            checkOutput("out_valid", 32'(out_valid_o), 32'(expQ.size() > 0));
            if (expQ.size() > 0) begin
                checkOutput("out_data", 32'(out_data_o), 32'(expQ[0]));
                if (out_ready_i)
                    void'(expQ.pop_front());
            end
            checkOutput("frame_cnt", 32'(frame_cnt_o), 32'(mFrames));
            checkOutput("seq_err", 32'(seq_err_o), 32'(mErr));
            checkOutput("overflow", 32'(overflow_o), 32'(mOvf));
        end
    end

    task automatic applyStimulus(input bit en, input bit dclk, input logic [3:0] oddV,
                                 input logic [3:0] evenV, input bit rdy);
        @(posedge clk_i);
        #1;
        en_i        = en;
        dclk_i      = dclk;
        odd_i       = dclk ? 4'bz : oddV;
        even_i      = dclk ? evenV : 4'bz;
        out_ready_i = rdy;
    endtask

    task automatic streamStep(input bit en, input bit rdy, input bit corrupt, input logic [3:0] bad);
        logic [3:0] v;
        v = corrupt ? bad : seqTab[upPos];
        applyStimulus(en, upPhase, v, v, rdy);
        upPos   = (upPos + 1) % 10;
        upPhase = ~upPhase;
    endtask

    task automatic runStream(input int n, input bit rdy);
        for (int i = 0; i < n; i++)
            streamStep(1'b1, rdy, 1'b0, 4'h0);
    endtask

    task automatic doReset();
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        en_i   = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("rst_out_data", 32'(out_data_o), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        checkOutput("rst_seq_err", 32'(seq_err_o), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        upPos   = 0;
        upPhase = 1'b0;
    endtask

    task automatic idleSample(input bit rdy);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, rdy);
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni      = 1'b0;
        en_i        = 1'b0;
        dclk_i      = 1'b0;
        odd_i       = 4'h0;
        even_i      = 4'h0;
        out_ready_i = 1'b1;
        upPos       = 0;
        upPhase     = 1'b0;
        modelReset();

        // T1 nominal: three frames with a ready consumer
        doReset();
        runStream(30, 1'b1);
        idleSample(1'b1);
        checkOutput("t1_frames", 32'(frame_cnt_o), 32'd3);
        checkOutput("t1_seq_err", 32'(seq_err_o), 32'd0);
        checkOutput("t1_overflow", 32'(overflow_o), 32'd0);

        // T2 backpressure: FIFO fills with the first four bytes, the rest are dropped
        doReset();
        runStream(20, 1'b0);
        idleSample(1'b0);
        checkOutput("t2_head", 32'(out_data_o), 32'h89);
        checkOutput("t2_overflow", 32'(overflow_o), 32'd1);
        checkOutput("t2_frames", 32'(frame_cnt_o), 32'd2);
        for (int i = 0; i < 6; i++)
            idleSample(1'b1);
        checkOutput("t2_drained", 32'(out_valid_o), 32'd0);

        // T3 bad nibble: 4 where 7 is expected in the second frame
        doReset();
        for (int i = 0; i < 30; i++)
            streamStep(1'b1, 1'b1, (i == 12), 4'h4);
        idleSample(1'b1);
        checkOutput("t3_seq_err", 32'(seq_err_o), 32'd1);
        checkOutput("t3_frames", 32'(frame_cnt_o), 32'd3);

        // T4 alignment: enable arrives on the even phase of the closing F nibble
        doReset();
        for (int i = 0; i < 9; i++)
            streamStep(1'b0, 1'b1, 1'b0, 4'h0);
        runStream(21, 1'b1);
        idleSample(1'b1);
        checkOutput("t4_seq_err", 32'(seq_err_o), 32'd0);
        checkOutput("t4_frames", 32'(frame_cnt_o), 32'd2);

        // T5 phase slip: the odd phase repeats once
        doReset();
        runStream(5, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 1'b1);
        runStream(15, 1'b1);
        idleSample(1'b1);
        checkOutput("t5_seq_err", 32'(seq_err_o), 32'd1);
        checkOutput("t5_frames", 32'(frame_cnt_o), 32'd2);

        // T6 reset mid-pair with a byte waiting in the FIFO
        doReset();
        runStream(3, 1'b0);
        doReset();
        runStream(20, 1'b1);
        idleSample(1'b1);
        checkOutput("t6_seq_err", 32'(seq_err_o), 32'd0);
        checkOutput("t6_frames", 32'(frame_cnt_o), 32'd2);

        // Random traffic: gated enable, bursty consumer, corrupt nibbles and phase slips
        doReset();
        for (int i = 0; i < 600; i++) begin
            bit       en;
            bit       rdy;
            bit       corrupt;
            bit       slip;
            logic [3:0] v;
            en      = ($urandom_range(0, 19) != 0);
            rdy     = ($urandom_range(0, 2) != 0);
            corrupt = ($urandom_range(0, 9) == 0);
            slip    = ($urandom_range(0, 19) == 0);
            v       = 4'($urandom_range(0, 15));
            if (slip)
                applyStimulus(en, upPhase, v, v, rdy);
            else
                streamStep(en, rdy, corrupt, v);
        end
        for (int i = 0; i < 8; i++)
            idleSample(1'b1);
        checkOutput("final_empty", 32'(out_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
